// File: rtl/walk_request_bank.sv
// Pedestrian walk-request bank: latches button presses per crossing and offers
// them one at a time, round-robin, to the light controller with a post-service lockout.
module walk_request_bank #(
    parameter int N_CH     = 4,
    parameter int LOCK_CYC = 16,
    localparam int CH_W    = $clog2(N_CH)
) (
    input  logic            clk,
    input  logic            wr_reset,
    input  logic [N_CH-1:0] btn_sync,
    input  logic [N_CH-1:0] clr,
    input  logic            gnt_ack,
    output logic [N_CH-1:0] pend,
    output logic [N_CH-1:0] lock,
    output logic            gnt_valid,
    output logic [CH_W-1:0] gnt_ch
);

    // A zero lockout still needs a 1-bit counter so the logic stays legal.
    localparam int CNT_W = (LOCK_CYC > 0) ? $clog2(LOCK_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] LOCK_VAL = CNT_W'(LOCK_CYC);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_OFFER = 1'b1;

    logic [0:0]      state_reg;
    logic [N_CH-1:0] btn_prev_reg;
    logic [N_CH-1:0] pend_reg;
    logic [N_CH-1:0] pend_next;
    logic [N_CH-1:0] lock_vec;
    logic [N_CH-1:0] press;
    logic [N_CH-1:0] ack_hit;
    logic [CH_W-1:0] ptr_reg;
    logic [CH_W-1:0] gnt_ch_reg;
    logic            gnt_valid_reg;
    logic            found;
    logic [CH_W-1:0] sel;
    int              cand;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;
            logic             lock_bit_reg;

            assign press[gi]   = btn_sync[gi] & ~btn_prev_reg[gi];
            assign ack_hit[gi] = (state_reg == S_OFFER) && gnt_ack && (gnt_ch_reg == CH_W'(gi));

            // Cancel and service both beat a new press; presses during lockout are dropped.
            assign pend_next[gi] = clr[gi]                          ? 1'b0 :
                                   ack_hit[gi]                      ? 1'b0 :
                                   (press[gi] & ~lock_vec[gi])      ? 1'b1 :
                                                                      pend_reg[gi];

            assign cnt_next = ack_hit[gi]       ? LOCK_VAL :
                              (cnt_reg != '0)   ? cnt_reg - 1'b1 :
                                                  cnt_reg;

            always_ff @(posedge clk or posedge wr_reset) begin
                if (wr_reset) begin
                    cnt_reg      <= '0;
                    lock_bit_reg <= 1'b0;
                end else begin
                    cnt_reg      <= cnt_next;
                    lock_bit_reg <= (cnt_next != '0);
                end
            end

            assign lock_vec[gi] = lock_bit_reg;
        end
    endgenerate

    // Round-robin search starting at ptr_reg, wrapping past the top channel.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = 0;
        for (int off = 0; off < N_CH; off++) begin
            cand = int'(ptr_reg) + off;
            if (cand >= N_CH) begin
                cand = cand - N_CH;
            end
            if (!found && pend_reg[CH_W'(cand)]) begin
                found = 1'b1;
                sel   = CH_W'(cand);
            end
        end
    end

    always_ff @(posedge clk or posedge wr_reset) begin
        if (wr_reset) begin
            state_reg     <= S_IDLE;
            btn_prev_reg  <= '1;
            pend_reg      <= '0;
            ptr_reg       <= '0;
            gnt_ch_reg    <= '0;
            gnt_valid_reg <= 1'b0;
        end else begin
            btn_prev_reg <= btn_sync;
            pend_reg     <= pend_next;
            case (state_reg)
                S_IDLE: begin
                    if (found) begin
                        gnt_ch_reg    <= sel;
                        gnt_valid_reg <= 1'b1;
                        state_reg     <= S_OFFER;
                    end
                end
                S_OFFER: begin
                    if (gnt_ack) begin
                        ptr_reg       <= (gnt_ch_reg == CH_W'(N_CH - 1)) ? '0 : gnt_ch_reg + 1'b1;
                        gnt_valid_reg <= 1'b0;
                        state_reg     <= S_IDLE;
                    end else if (!pend_next[gnt_ch_reg]) begin
                        // Offered request was cancelled: withdraw without advancing the pointer.
                        gnt_valid_reg <= 1'b0;
                        state_reg     <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign pend      = pend_reg;
    assign lock      = lock_vec;
    assign gnt_valid = gnt_valid_reg;
    assign gnt_ch    = gnt_ch_reg;

endmodule

// File: tb/tb_walk_request_bank.sv
// Self-checking bench for walk_request_bank: per-cycle vector table plus
// hand-written grant-order, lockout-timing and reset sequences.
module tb_walk_request_bank;

    logic       clk = 1'b0;
    logic       wr_reset = 1'b0;
    logic [3:0] btn_sync = 4'b0000;
    logic [3:0] clr = 4'b0000;
    logic       gnt_ack = 1'b0;
    logic [3:0] pend;
    logic [3:0] lock;
    logic       gnt_valid;
    logic [1:0] gnt_ch;

    int n_checks = 0;
    int n_fail   = 0;

    walk_request_bank #(.N_CH(4), .LOCK_CYC(16)) dut (
        .clk       (clk),
        .wr_reset  (wr_reset),
        .btn_sync  (btn_sync),
        .clr       (clr),
        .gnt_ack   (gnt_ack),
        .pend      (pend),
        .lock      (lock),
        .gnt_valid (gnt_valid),
        .gnt_ch    (gnt_ch)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         rep;
        logic [3:0] btn;
        logic [3:0] clr;
        logic       ack;
        logic [3:0] e_pend;
        logic [3:0] e_lock;
        logic       e_valid;
        logic [1:0] e_ch;
        logic       ck_lock;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs [NV];
    vec_t exp_q [$];
    int   grant_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t e;
        int   exp_ch;
        int   cycles;
        bit   prev_acked;

        //            rep btn      clr      ack   pend     lock     v     ch    ck
        vecs[0]  = '{1,  4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1};
        vecs[1]  = '{1,  4'b0100, 4'b0000, 1'b0, 4'b0100, 4'b0000, 1'b0, 2'd0, 1'b1};
        vecs[2]  = '{1,  4'b0000, 4'b0000, 1'b0, 4'b0100, 4'b0000, 1'b1, 2'd2, 1'b1};
        vecs[3]  = '{1,  4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0100, 1'b0, 2'd2, 1'b1};
        vecs[4]  = '{15, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0100, 1'b0, 2'd2, 1'b1};
        vecs[5]  = '{1,  4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b1};
        vecs[6]  = '{1,  4'b0010, 4'b0010, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b1};
        vecs[7]  = '{1,  4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b1};
        vecs[8]  = '{1,  4'b1000, 4'b0000, 1'b0, 4'b1000, 4'b0000, 1'b0, 2'd2, 1'b1};
        vecs[9]  = '{1,  4'b0000, 4'b0000, 1'b0, 4'b1000, 4'b0000, 1'b1, 2'd3, 1'b1};
        vecs[10] = '{1,  4'b0000, 4'b1000, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd3, 1'b1};
        vecs[11] = '{1,  4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd3, 1'b1};
        vecs[12] = '{1,  4'b1010, 4'b0000, 1'b0, 4'b1010, 4'b0000, 1'b0, 2'd3, 1'b1};
        vecs[13] = '{1,  4'b0000, 4'b0000, 1'b0, 4'b1010, 4'b0000, 1'b1, 2'd3, 1'b1};
        vecs[14] = '{1,  4'b0000, 4'b0000, 1'b1, 4'b0010, 4'b1000, 1'b0, 2'd3, 1'b1};
        vecs[15] = '{1,  4'b0000, 4'b0000, 1'b0, 4'b0010, 4'b1000, 1'b1, 2'd1, 1'b1};
        vecs[16] = '{1,  4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b1010, 1'b0, 2'd1, 1'b1};
        vecs[17] = '{1,  4'b0100, 4'b0000, 1'b0, 4'b0100, 4'b1010, 1'b0, 2'd1, 1'b1};
        vecs[18] = '{1,  4'b0000, 4'b0000, 1'b0, 4'b0100, 4'b1010, 1'b1, 2'd2, 1'b1};
        vecs[19] = '{1,  4'b0001, 4'b0000, 1'b0, 4'b0101, 4'b1010, 1'b1, 2'd2, 1'b1};
        vecs[20] = '{1,  4'b0000, 4'b0000, 1'b0, 4'b0101, 4'b1010, 1'b1, 2'd2, 1'b1};
        vecs[21] = '{1,  4'b0000, 4'b0000, 1'b1, 4'b0001, 4'b1110, 1'b0, 2'd2, 1'b1};
        vecs[22] = '{1,  4'b0000, 4'b0000, 1'b0, 4'b0001, 4'b1110, 1'b1, 2'd0, 1'b1};
        vecs[23] = '{1,  4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b1111, 1'b0, 2'd0, 1'b1};
        vecs[24] = '{1,  4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b1111, 1'b0, 2'd0, 1'b1};
        vecs[25] = '{14, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
        vecs[26] = '{1,  4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1};

        // Asynchronous reset, checked before any clock edge.
        #2 wr_reset = 1'b1;
        #1;
        chk("rst_pend",  pend, 0);
        chk("rst_lock",  lock, 0);
        chk("rst_valid", gnt_valid, 0);
        chk("rst_ch",    gnt_ch, 0);
        step();
        wr_reset = 1'b0;

        for (int r = 0; r < NV; r++) begin
            for (int k = 0; k < vecs[r].rep; k++) begin
                btn_sync = vecs[r].btn;
                clr      = vecs[r].clr;
                gnt_ack  = vecs[r].ack;
                exp_q.push_back(vecs[r]);
                step();
                e = exp_q.pop_front();
                chk($sformatf("r%0d.%0d pend", r, k), pend, e.e_pend);
                chk($sformatf("r%0d.%0d valid", r, k), gnt_valid, e.e_valid);
                chk($sformatf("r%0d.%0d ch", r, k), gnt_ch, e.e_ch);
                if (e.ck_lock) chk($sformatf("r%0d.%0d lock", r, k), lock, e.e_lock);
                $display("vec r%0d.%0d btn=%b clr=%b ack=%b -> pend=%b lock=%b v=%b ch=%0d",
                         r, k, vecs[r].btn, vecs[r].clr, vecs[r].ack, pend, lock, gnt_valid, gnt_ch);
            end
        end
        btn_sync = 4'b0000;
        clr      = 4'b0000;
        gnt_ack  = 1'b0;

        // Button held through reset release must not register as a press.
        btn_sync = 4'b0001;
        wr_reset = 1'b1;
        #1;
        chk("hold_rst_pend", pend, 0);
        step();
        wr_reset = 1'b0;
        step();
        chk("hold_pend_a", pend, 0);
        step();
        chk("hold_pend_b", pend, 0);
        chk("hold_valid", gnt_valid, 0);
        btn_sync = 4'b0000;
        step();

        // All four pressed together from ptr=0: grants 0,1,2,3 with a gap after each ack.
        btn_sync = 4'b1111;
        for (int c = 0; c < 4; c++) grant_q.push_back(c);
        step();
        btn_sync   = 4'b0000;
        prev_acked = 1'b0;
        cycles     = 0;
        while (grant_q.size() > 0 && cycles < 40) begin
            if (prev_acked) chk("rr_gap", gnt_valid, 0);
            if (gnt_valid) begin
                exp_ch = grant_q.pop_front();
                chk("rr_order", gnt_ch, exp_ch);
                $display("grant ch=%0d expected=%0d", gnt_ch, exp_ch);
                gnt_ack    = 1'b1;
                prev_acked = 1'b1;
            end else begin
                gnt_ack    = 1'b0;
                prev_acked = 1'b0;
            end
            step();
            cycles++;
        end
        gnt_ack = 1'b0;
        chk("rr_done", grant_q.size(), 0);
        chk("rr_gap_last", gnt_valid, 0);
        chk("rr_pend_empty", pend, 0);

        // Lockout window on ch1: press at ack+5 dropped, press at ack+17 accepted.
        repeat (20) step();
        chk("lk_idle_lock", lock, 0);
        btn_sync = 4'b0010;
        step();
        btn_sync = 4'b0000;
        step();
        chk("lk_offer_v", gnt_valid, 1);
        chk("lk_offer_ch", gnt_ch, 1);
        gnt_ack = 1'b1;
        step();
        gnt_ack = 1'b0;
        chk("lk_lock_on", lock[1], 1);
        repeat (4) step();
        btn_sync = 4'b0010;
        step();
        btn_sync = 4'b0000;
        chk("lk_early_press", pend[1], 0);
        $display("lockout early press pend=%b lock=%b", pend, lock);
        repeat (10) step();
        chk("lk_last_cycle", lock[1], 1);
        step();
        chk("lk_released", lock[1], 0);
        btn_sync = 4'b0010;
        step();
        btn_sync = 4'b0000;
        chk("lk_late_press", pend[1], 1);
        $display("lockout late press pend=%b lock=%b", pend, lock);
        step();
        chk("lk_reoffer_v", gnt_valid, 1);
        chk("lk_reoffer_ch", gnt_ch, 1);

        // Reset between clock edges while an offer is active.
        #2 wr_reset = 1'b1;
        #1;
        chk("mid_rst_valid", gnt_valid, 0);
        chk("mid_rst_pend", pend, 0);
        chk("mid_rst_ch", gnt_ch, 0);
        $display("mid-offer reset v=%b pend=%b", gnt_valid, pend);
        step();
        wr_reset = 1'b0;
        step();
        chk("post_rst_valid", gnt_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
